// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cache-line to burst-memory adaptor.
package cacheline_adaptor_pkg;

  localparam int unsigned LINE_W  = 256;
  localparam int unsigned BEAT_W  = 64;
  localparam int unsigned N_BEATS = 4;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned ADDR_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } adaptor_state_t;

  // Clears the low `offset` address bits so bursts always start on a line boundary.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr,
                                                   input int unsigned       offset);
    logic [ADDR_W-1:0] mask;
    mask = {ADDR_W{1'b1}} << offset;
    return addr & mask;
  endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side line port and memory-side burst port of the adaptor, bundled.
interface cacheline_adaptor_if;
  import cacheline_adaptor_pkg::*;

  logic [LINE_W-1:0] line_i;
  logic [LINE_W-1:0] line_o;
  logic [ADDR_W-1:0] address_i;
  logic              read_i;
  logic              write_i;
  logic              resp_o;
  logic [BEAT_W-1:0] burst_i;
  logic [BEAT_W-1:0] burst_o;
  logic [ADDR_W-1:0] address_o;
  logic              read_o;
  logic              write_o;
  logic              resp_i;

  // Adaptor view.
  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  // Cache plus memory view, as driven by the surrounding system.
  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// Carries one 256-bit cache line read/write out as four 64-bit memory beats,
// then returns a single-cycle response to the cache.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_beat   = 64,
  parameter int unsigned n_beats  = 4
) (
  input  logic               clk,
  input  logic               rst,
  cacheline_adaptor_if.slave bus
);

  adaptor_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [LINE_W-1:0] wr_line_q;
  logic [LINE_W-1:0] rd_line_q;
  logic [ADDR_W-1:0] addr_q;

  logic accept_wr, accept_rd, beat_fire, last_beat;

  // Write wins when both requests are raised together.
  assign accept_wr = (state_q == IDLE) && bus.write_i;
  assign accept_rd = (state_q == IDLE) && !bus.write_i && bus.read_i;
  assign beat_fire = ((state_q == READ) || (state_q == WRITE)) && bus.resp_i;
  assign last_beat = (cnt_q == CNT_W'(n_beats - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept_wr)      state_d = WRITE;
        else if (accept_rd) state_d = READ;
      end
      READ:    if (bus.resp_i && last_beat) state_d = DONE;
      WRITE:   if (bus.resp_i && last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.read_o    = 1'b0;
    bus.write_o   = 1'b0;
    bus.resp_o    = 1'b0;
    bus.burst_o   = wr_line_q[cnt_q*s_beat +: s_beat];
    bus.address_o = addr_q;
    bus.line_o    = rd_line_q;
    unique case (state_q)
      READ:    bus.read_o  = 1'b1;
      WRITE:   bus.write_o = 1'b1;
      DONE:    bus.resp_o  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cnt_q <= '0;
    else if (accept_wr || accept_rd) cnt_q <= '0;
    else if (beat_fire)             cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        addr_q <= '0;
    else if (accept_wr || accept_rd) addr_q <= line_align(bus.address_i, s_offset);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            wr_line_q <= '0;
    else if (accept_wr) wr_line_q <= bus.line_i;
  end

  // Read data is kept after DONE until the next read overwrites it beat by beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    rd_line_q <= '0;
    else if ((state_q == READ) && bus.resp_i)   rd_line_q[cnt_q*s_beat +: s_beat] <= bus.burst_i;
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor.
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [LINE_W-1:0] rd_line;

  cacheline_adaptor_if bus();

  cacheline_adaptor #(.s_offset(5), .s_beat(64), .n_beats(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.line_i = '0; bus.address_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
    bus.burst_i = '0; bus.resp_i = 1'b0;
    tick();
    n_cmp++; if ({bus.resp_o, bus.read_o, bus.write_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctrl: got %b required 000", {bus.resp_o, bus.read_o, bus.write_o}); end
    n_cmp++; if (bus.line_o !== '0) begin
      n_err++; $display("FAIL reset_line_o: got %h required 0", bus.line_o); end
    n_cmp++; if (bus.burst_o !== '0 || bus.address_o !== '0) begin
      n_err++; $display("FAIL reset_burst_addr: got %h/%h required 0/0", bus.burst_o, bus.address_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    int first, pulses;
    rd_line = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    bus.address_i = 32'h0000_1234; bus.read_i = 1'b1;
    tick();
    bus.read_i = 1'b0; bus.address_i = '0;
    n_cmp++; if (bus.address_o !== 32'h0000_1220) begin
      n_err++; $display("FAIL read_addr: got %h required 00001220", bus.address_o); end
    first = 0; pulses = 0;
    for (int c = 2; c <= 10; c++) begin
      if (c <= 5) begin
        n_cmp++; if (bus.read_o !== 1'b1 || bus.write_o !== 1'b0) begin
          n_err++; $display("FAIL read_req c=%0d: got r=%b w=%b required r=1 w=0", c, bus.read_o, bus.write_o); end
        bus.resp_i = 1'b1; bus.burst_i = {8{8'(8'h11 * (c - 1))}};
      end else begin
        bus.resp_i = 1'b0; bus.burst_i = '1;
      end
      tick();
      if (bus.resp_o === 1'b1) begin pulses++; if (first == 0) first = c; end
    end
    n_cmp++; if (first != 5 || pulses != 1) begin
      n_err++; $display("FAIL read_resp: got at=%0d pulses=%0d required at=5 pulses=1", first, pulses); end
    n_cmp++; if (bus.line_o !== rd_line) begin
      n_err++; $display("FAIL read_line: got %h required %h", bus.line_o, rd_line); end
    n_cmp++; if (bus.read_o !== 1'b0) begin
      n_err++; $display("FAIL read_idle: got read_o=%b required 0", bus.read_o); end
  endtask

  task automatic test_write_gap();
    logic [BEAT_W-1:0] w [4];
    logic              g;
    int acc, first, pulses, rd_seen;
    w[0] = 64'h0000_5555_0000_BEEF; w[1] = 64'h1111_ABCD_1111_ABCD;
    w[2] = 64'h2222_F00D_2222_F00D; w[3] = 64'hDEAD_3333_CAFE_3333;
    bus.line_i = {w[3], w[2], w[1], w[0]}; bus.address_i = 32'h8000_0040; bus.write_i = 1'b1;
    tick();
    bus.write_i = 1'b0; bus.line_i = '1; bus.address_i = '0;
    n_cmp++; if (bus.address_o !== 32'h8000_0040 || bus.write_o !== 1'b1) begin
      n_err++; $display("FAIL write_start: got addr=%h w=%b required 80000040 1", bus.address_o, bus.write_o); end
    acc = 0; first = 0; pulses = 0; rd_seen = 0;
    for (int c = 2; c <= 12; c++) begin
      g = (c == 2 || c == 3 || c == 6 || c == 7);
      if (acc < 4) begin
        n_cmp++; if (bus.write_o !== 1'b1 || bus.burst_o !== w[acc]) begin
          n_err++; $display("FAIL write_beat c=%0d: got w=%b %h required 1 %h", c, bus.write_o, bus.burst_o, w[acc]); end
      end
      bus.resp_i = g;
      tick();
      if (g && acc < 4) acc++;
      if (bus.read_o === 1'b1) rd_seen++;
      if (bus.resp_o === 1'b1) begin pulses++; if (first == 0) first = c; end
    end
    bus.resp_i = 1'b0;
    n_cmp++; if (first != 7 || pulses != 1 || rd_seen != 0) begin
      n_err++; $display("FAIL write_resp: got at=%0d pulses=%0d rd=%0d required 7 1 0", first, pulses, rd_seen); end
    n_cmp++; if (bus.line_o !== rd_line) begin
      n_err++; $display("FAIL line_hold: got %h required %h", bus.line_o, rd_line); end
  endtask

  task automatic test_both();
    logic [BEAT_W-1:0] v [4];
    int acc, first, pulses, rd_seen;
    for (int k = 0; k < 4; k++) v[k] = {8{8'(8'hA0 + k)}};
    bus.line_i = {v[3], v[2], v[1], v[0]}; bus.address_i = 32'h0000_0107;
    bus.read_i = 1'b1; bus.write_i = 1'b1;
    tick();
    bus.read_i = 1'b0; bus.write_i = 1'b0; bus.line_i = '0;
    n_cmp++; if (bus.write_o !== 1'b1 || bus.read_o !== 1'b0 || bus.address_o !== 32'h0000_0100) begin
      n_err++; $display("FAIL both_start: got w=%b r=%b a=%h required 1 0 00000100", bus.write_o, bus.read_o, bus.address_o); end
    acc = 0; first = 0; pulses = 0; rd_seen = 0;
    for (int c = 2; c <= 8; c++) begin
      if (acc < 4) begin
        n_cmp++; if (bus.burst_o !== v[acc]) begin
          n_err++; $display("FAIL both_beat c=%0d: got %h required %h", c, bus.burst_o, v[acc]); end
      end
      bus.resp_i = (c <= 5);
      tick();
      if (c <= 5) acc++;
      if (bus.read_o === 1'b1) rd_seen++;
      if (bus.resp_o === 1'b1) begin pulses++; if (first == 0) first = c; end
    end
    bus.resp_i = 1'b0;
    n_cmp++; if (first != 5 || pulses != 1 || rd_seen != 0) begin
      n_err++; $display("FAIL both_resp: got at=%0d pulses=%0d rd=%0d required 5 1 0", first, pulses, rd_seen); end
    n_cmp++; if (bus.line_o !== rd_line) begin
      n_err++; $display("FAIL both_line_hold: got %h required %h", bus.line_o, rd_line); end
  endtask

  task automatic test_back_to_back();
    logic [BEAT_W-1:0] b [4];
    logic [BEAT_W-1:0] wv [4];
    logic [LINE_W-1:0] exp_line;
    for (int k = 0; k < 4; k++) begin
      b[k]  = {4{16'(16'hB000 + k)}};
      wv[k] = {8{8'(8'hC0 + k)}};
    end
    exp_line = {b[3], b[2], b[1], b[0]};
    // resp_i stays high throughout, including the IDLE/DONE cycles where it must be ignored.
    bus.address_i = 32'h0000_0040; bus.read_i = 1'b1; bus.resp_i = 1'b1; bus.burst_i = '1;
    tick();
    bus.read_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.burst_i = b[k];
      tick();
    end
    bus.burst_i = '1;
    n_cmp++; if (bus.resp_o !== 1'b1 || bus.read_o !== 1'b0) begin
      n_err++; $display("FAIL b2b_rd_done: got resp=%b r=%b required 1 0", bus.resp_o, bus.read_o); end
    n_cmp++; if (bus.line_o !== exp_line) begin
      n_err++; $display("FAIL b2b_rd_line: got %h required %h", bus.line_o, exp_line); end
    tick();
    n_cmp++; if ({bus.resp_o, bus.read_o, bus.write_o} !== 3'b000 || bus.line_o !== exp_line) begin
      n_err++; $display("FAIL b2b_idle: got ctrl=%b line=%h required 000 %h", {bus.resp_o, bus.read_o, bus.write_o}, bus.line_o, exp_line); end
    bus.line_i = {wv[3], wv[2], wv[1], wv[0]}; bus.address_i = 32'h0000_0060; bus.write_i = 1'b1;
    tick();
    bus.write_i = 1'b0; bus.line_i = '0;
    n_cmp++; if (bus.write_o !== 1'b1 || bus.address_o !== 32'h0000_0060) begin
      n_err++; $display("FAIL b2b_wr_start: got w=%b a=%h required 1 00000060", bus.write_o, bus.address_o); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (bus.burst_o !== wv[k] || bus.write_o !== 1'b1) begin
        n_err++; $display("FAIL b2b_wr_beat%0d: got %h w=%b required %h 1", k, bus.burst_o, bus.write_o, wv[k]); end
      tick();
    end
    n_cmp++; if (bus.resp_o !== 1'b1 || bus.write_o !== 1'b0) begin
      n_err++; $display("FAIL b2b_wr_done: got resp=%b w=%b required 1 0", bus.resp_o, bus.write_o); end
    tick();
    n_cmp++; if (bus.resp_o !== 1'b0 || bus.line_o !== exp_line) begin
      n_err++; $display("FAIL b2b_end: got resp=%b line=%h required 0 %h", bus.resp_o, bus.line_o, exp_line); end
    bus.resp_i = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    bus.address_i = 32'h0000_2000; bus.read_i = 1'b1;
    tick();
    bus.read_i = 1'b0; bus.resp_i = 1'b1;
    bus.burst_i = 64'hFEED_0001_FEED_0001; tick();
    bus.burst_i = 64'hFEED_0002_FEED_0002; tick();
    bus.resp_i = 1'b0;
    n_cmp++; if (bus.line_o[127:0] !== {64'hFEED_0002_FEED_0002, 64'hFEED_0001_FEED_0001}) begin
      n_err++; $display("FAIL partial_line: got %h required feed0002feed0002feed0001feed0001", bus.line_o[127:0]); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({bus.resp_o, bus.read_o, bus.write_o} !== 3'b000) begin
      n_err++; $display("FAIL rst_mid_ctrl: got %b required 000", {bus.resp_o, bus.read_o, bus.write_o}); end
    n_cmp++; if (bus.line_o !== '0 || bus.address_o !== '0) begin
      n_err++; $display("FAIL rst_mid_clear: got line=%h a=%h required 0 0", bus.line_o, bus.address_o); end
    #1 rst = 1'b0;
    bus.resp_i = 1'b1;
    tick(); tick();
    n_cmp++; if (bus.read_o !== 1'b0 || bus.resp_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_idle: got r=%b resp=%b required 0 0", bus.read_o, bus.resp_o); end
    bus.resp_i = 1'b0;
    bus.address_i = 32'h0000_3010; bus.read_i = 1'b1;
    tick();
    bus.read_i = 1'b0;
    n_cmp++; if (bus.read_o !== 1'b1 || bus.address_o !== 32'h0000_3000) begin
      n_err++; $display("FAIL rst_mid_restart: got r=%b a=%h required 1 00003000", bus.read_o, bus.address_o); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_gap();
    test_both();
    test_back_to_back();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
